slinky_seq: RTL and testbench



---
 rtl/slinky_seq.sv | 241 ++++++++++++++++++++++++
 tb/tb_slinky_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/slinky_seq.sv
// slinky_seq: multi-channel auto-increment SDRAM windows for the Apple II bus.
// One SDRAM access per PHI0 cycle on a 16-phase C25M sequencer, plus refresh.
module slinky_seq #(
  parameter int AW       = 24,
  parameter int NCH      = 2,
  parameter int REF_DIV  = 4,
  parameter int IDLE_REF = 1024
) (
  input  logic        C25M,
  input  logic        RES,
  input  logic        PHI0,
  input  logic        InitDone,
  input  logic [3:0]  RA,
  input  logic        nDEVSEL,
  input  logic        nWE,
  input  logic [7:0]  RDin,
  output logic [7:0]  RDout,
  output logic        RDOE,
  input  logic [7:0]  SDin,
  output logic [7:0]  SDout,
  output logic        SDOE,
  output logic        RCKE,
  output logic        nRCS,
  output logic        nRAS,
  output logic        nCAS,
  output logic        nSWE,
  output logic        DQML,
  output logic        DQMH,
  output logic [1:0]  SBA,
  output logic [12:0] SA
);

  localparam int IW = $clog2(IDLE_REF) + 1;
  localparam logic [23:0] AMASK = 24'hFFFFFF >> (24 - AW);
  localparam logic [7:0]  HPAD  = ~AMASK[23:16];

  // {nRCS, nRAS, nCAS, nSWE}
  localparam logic [3:0] C_NOP = 4'b1111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;

  logic [3:0]    ps_q, ps_d;
  logic [2:0]    sync_q, sync_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [3:0]    rcnt_q, rcnt_d;
  logic          rdue_q, rdue_d;
  logic          icyc_q, icyc_d;
  logic [3:0]    rra_q, rra_d;
  logic          rsel_q, rsel_d;
  logic          rrd_q, rrd_d;
  logic [23:0]   a_q [4];
  logic [23:0]   a_d [4];
  logic [7:0]    rdout_q, rdout_d;
  logic [7:0]    sdout_q, sdout_d;
  logic          rdoe_q, rdoe_d;
  logic          sdoe_q, sdoe_d;
  logic          rcke_q, rcke_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [1:0]    dqm_q, dqm_d;
  logic [1:0]    sba_q, sba_d;
  logic [12:0]   sa_q, sa_d;

  logic        phi_rise, start;
  logic        data, rd, wr;
  logic [1:0]  ch, off;
  logic [23:0] cur, nxt;
  logic [12:0] col;
  logic [7:0]  rbyte;

  always_comb begin
    sync_d   = {sync_q[1:0], PHI0};
    phi_rise = sync_q[1] & ~sync_q[2];
    ps_d     = ps_q;
    idle_d   = idle_q;
    rcnt_d   = rcnt_q;
    rdue_d   = rdue_q;
    icyc_d   = icyc_q;
    rra_d    = rra_q;
    rsel_d   = rsel_q;
    rrd_d    = rrd_q;
    a_d      = a_q;
    rdout_d  = rdout_q;
    sdout_d  = sdout_q;
    rdoe_d   = 1'b0;
    sdoe_d   = 1'b0;
    rcke_d   = 1'b1;
    cmd_d    = C_NOP;
    dqm_d    = 2'b11;
    sba_d    = sba_q;
    sa_d     = sa_q;
    start    = 1'b0;

    if (ps_q == 4'd0) begin
      if (phi_rise) begin
        start  = 1'b1;
        icyc_d = 1'b0;
        rdue_d = (rcnt_q == 4'(REF_DIV - 1));
        rcnt_d = rdue_d ? 4'd0 : rcnt_q + 4'd1;
      end else if (idle_q == IW'(IDLE_REF - 1)) begin
        start  = 1'b1;
        icyc_d = 1'b1;
        rdue_d = 1'b1;
      end
      idle_d = start ? '0 : idle_q + IW'(1);
      ps_d   = start ? 4'd1 : 4'd0;
    end else begin
      ps_d   = ps_q + 4'd1;
      idle_d = '0;
    end

    if (ps_q == 4'd1) begin
      rra_d  = RA;
      rrd_d  = nWE;
      rsel_d = ~nDEVSEL & ~icyc_q & (int'(RA[3:2]) < NCH);
    end

    ch   = rra_d[3:2];
    off  = rra_d[1:0];
    cur  = a_q[ch];
    col  = {3'b001, 1'b0, cur[9:1]};
    data = rsel_d & (off == 2'd3);
    rd   = rsel_d & rrd_d;
    wr   = rsel_d & ~rrd_d;

    if (InitDone) begin
      case (ps_d)
        4'd2: if (data) begin
          cmd_d = C_ACT;
          sba_d = {1'b0, cur[23]};
          sa_d  = cur[22:10];
        end
        4'd3: if (data & rd) begin
          cmd_d = C_RD;
          sa_d  = col;
          dqm_d = {~cur[0], cur[0]};
        end
        4'd9: if (data & wr) begin
          cmd_d  = C_WR;
          sa_d   = col;
          dqm_d  = {~cur[0], cur[0]};
          sdoe_d = 1'b1;
        end
        4'd11: if (rdue_d) begin
          cmd_d = C_PRE;
          sa_d  = 13'h0400;
        end
        4'd12: if (rdue_d) cmd_d = C_REF;
        default: ;
      endcase
    end
    rdoe_d = InitDone & rd & (ps_d >= 4'd6);

    case (off)
      2'd0:    rbyte = cur[7:0];
      2'd1:    rbyte = cur[15:8];
      default: rbyte = cur[23:16] | HPAD;
    endcase

    // slinky carry: bit 7/15 falling on a byte write bumps the next byte up
    nxt = cur;
    case (off)
      2'd0: begin
        nxt[7:0] = RDin;
        if (cur[7] & ~RDin[7]) nxt[23:8] = cur[23:8] + 16'd1;
      end
      2'd1: begin
        nxt[15:8] = RDin;
        if (cur[15] & ~RDin[7]) nxt[23:16] = cur[23:16] + 8'd1;
      end
      default: nxt[23:16] = RDin;
    endcase

    case (ps_q)
      4'd5:  if (rd) rdout_d = data ? SDin : rbyte;
      4'd8:  sdout_d = RDin;
      4'd9:  if (wr & ~data) a_d[ch] = nxt & AMASK;
      4'd10: if (data) a_d[ch] = (cur + 24'd1) & AMASK;
      default: ;
    endcase

    for (int i = NCH; i < 4; i++) a_d[i] = '0;
  end

  always_ff @(posedge C25M or posedge RES) begin
    if (RES) begin
      ps_q    <= '0;
      sync_q  <= '0;
      idle_q  <= '0;
      rcnt_q  <= '0;
      rdue_q  <= 1'b0;
      icyc_q  <= 1'b0;
      rra_q   <= '0;
      rsel_q  <= 1'b0;
      rrd_q   <= 1'b0;
      for (int i = 0; i < 4; i++) a_q[i] <= '0;
      rdout_q <= '0;
      sdout_q <= '0;
      rdoe_q  <= 1'b0;
      sdoe_q  <= 1'b0;
      rcke_q  <= 1'b0;
      cmd_q   <= C_NOP;
      dqm_q   <= 2'b11;
      sba_q   <= '0;
      sa_q    <= '0;
    end else begin
      ps_q    <= ps_d;
      sync_q  <= sync_d;
      idle_q  <= idle_d;
      rcnt_q  <= rcnt_d;
      rdue_q  <= rdue_d;
      icyc_q  <= icyc_d;
      rra_q   <= rra_d;
      rsel_q  <= rsel_d;
      rrd_q   <= rrd_d;
      a_q     <= a_d;
      rdout_q <= rdout_d;
      sdout_q <= sdout_d;
      rdoe_q  <= rdoe_d;
      sdoe_q  <= sdoe_d;
      rcke_q  <= rcke_d;
      cmd_q   <= cmd_d;
      dqm_q   <= dqm_d;
      sba_q   <= sba_d;
      sa_q    <= sa_d;
    end
  end

  assign {nRCS, nRAS, nCAS, nSWE} = cmd_q;
  assign {DQMH, DQML} = dqm_q;
  assign RDout = rdout_q;
  assign RDOE  = rdoe_q;
  assign SDout = sdout_q;
  assign SDOE  = sdoe_q;
  assign RCKE  = rcke_q;
  assign SBA   = sba_q;
  assign SA    = sa_q;

endmodule

// File: tb/tb_slinky_seq.sv
// tb_slinky_seq: directed plus random bus cycles against a behavioural
// model of the slinky windows, SDRAM commands and refresh schedule.
`timescale 1ns/1ps
module tb_slinky_seq;

  localparam int AW       = 20;
  localparam int NCH      = 3;
  localparam int REF_DIV  = 4;
  localparam int IDLE_REF = 1024;
  localparam logic [23:0] MASK = 24'((32'd1 << AW) - 32'd1);
  localparam logic [3:0] NOP  = 4'hF;
  localparam logic [3:0] ACT  = 4'h3;
  localparam logic [3:0] RDC  = 4'h5;
  localparam logic [3:0] WRC  = 4'h4;
  localparam logic [3:0] PRE  = 4'h2;
  localparam logic [3:0] AREF = 4'h1;
  // sample index k holds slot n when k = n + LAT (two sync flops + edge)
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        res, phi0, init_done;
  logic [3:0]  ra;
  logic        ndevsel, nwe;
  logic [7:0]  rdin, sdin;
  logic [7:0]  rdout, sdout;
  logic        rdoe, sdoe, rcke;
  logic        nrcs, nras, ncas, nswe, dqml, dqmh;
  logic [1:0]  sba;
  logic [12:0] sa;
  logic [3:0]  cmd;

  assign cmd = {nrcs, nras, ncas, nswe};

  slinky_seq #(
    .AW(AW), .NCH(NCH), .REF_DIV(REF_DIV), .IDLE_REF(IDLE_REF)
  ) dut (
    .C25M(clk), .RES(res), .PHI0(phi0), .InitDone(init_done),
    .RA(ra), .nDEVSEL(ndevsel), .nWE(nwe),
    .RDin(rdin), .RDout(rdout), .RDOE(rdoe),
    .SDin(sdin), .SDout(sdout), .SDOE(sdoe),
    .RCKE(rcke), .nRCS(nrcs), .nRAS(nras), .nCAS(ncas), .nSWE(nswe),
    .DQML(dqml), .DQMH(dqmh), .SBA(sba), .SA(sa)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [23:0] ma [4];
  int          mref;

  logic [3:0]  t_cmd   [20];
  logic [1:0]  t_sba   [20];
  logic [12:0] t_sa    [20];
  logic [1:0]  t_dqm   [20];
  logic        t_sdoe  [20];
  logic        t_rdoe  [20];
  logic [7:0]  t_sdout [20];
  logic [7:0]  t_rdout [20];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] wreg(input logic [23:0] a,
                                       input logic [1:0] off,
                                       input logic [7:0] d);
    int v;
    v = int'(a);
    if (off == 2'd0) begin
      v = (v & 'hFFFF00) + int'(d);
      if (a[7] && !d[7]) v = v + 'h100;
    end else if (off == 2'd1) begin
      v = (v & 'hFF00FF) + (int'(d) << 8);
      if (a[15] && !d[7]) v = v + 'h10000;
    end else begin
      v = (v & 'hFFFF) + (int'(d) << 16);
    end
    return 24'(v) & MASK;
  endfunction

  function automatic logic [7:0] rbyte(input logic [23:0] a,
                                       input logic [1:0] off,
                                       input logic [7:0] sd);
    int v;
    v = int'(a);
    case (off)
      2'd0: return 8'(v);
      2'd1: return 8'(v >> 8);
      2'd2: return 8'(v >> 16) | ~8'(MASK >> 16);
      default: return sd;
    endcase
  endfunction

  task automatic bus(input logic [3:0] r, input logic wn, input logic dn,
                     input logic [7:0] din, input logic [7:0] sd);
    logic [1:0]  ch, off;
    logic        sel, data, rd, wr, due, en;
    logic [23:0] a;
    logic [12:0] colx;
    logic [1:0]  dqx;
    @(negedge clk);
    ra = r; nwe = wn; ndevsel = dn; rdin = din; sdin = sd; phi0 = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk);
      #1;
      t_cmd[k] = cmd; t_sba[k] = sba; t_sa[k] = sa;
      t_dqm[k] = {dqmh, dqml}; t_sdoe[k] = sdoe; t_rdoe[k] = rdoe;
      t_sdout[k] = sdout; t_rdout[k] = rdout;
      if (k == 8) phi0 = 1'b0;
    end
    ch   = r[3:2];
    off  = r[1:0];
    sel  = !dn && (int'(ch) < NCH);
    data = sel && off == 2'd3;
    rd   = sel && wn;
    wr   = sel && !wn;
    en   = init_done;
    a    = ma[ch];
    due  = (mref == REF_DIV - 1);
    mref = due ? 0 : mref + 1;
    colx = 13'h400 | 13'((a >> 1) & 24'h1FF);
    dqx  = a[0] ? 2'b01 : 2'b10;

    chk("s2_cmd", t_cmd[2+LAT], (en && data) ? ACT : NOP);
    if (en && data) begin
      chk("s2_bank", t_sba[2+LAT], 32'(a >> 23));
      chk("s2_row", t_sa[2+LAT], 32'((a >> 10) & 24'h1FFF));
    end
    chk("s3_cmd", t_cmd[3+LAT], (en && data && rd) ? RDC : NOP);
    if (en && data && rd) begin
      chk("s3_col", t_sa[3+LAT], colx);
      chk("s3_dqm", t_dqm[3+LAT], dqx);
    end
    chk("s5_rdoe", t_rdoe[5+LAT], 0);
    chk("s6_rdoe", t_rdoe[6+LAT], en && rd);
    if (en && rd) chk("s6_rdout", t_rdout[6+LAT], rbyte(a, off, sd));
    chk("s9_cmd", t_cmd[9+LAT], (en && data && wr) ? WRC : NOP);
    chk("s9_sdoe", t_sdoe[9+LAT], en && data && wr);
    if (en && data && wr) begin
      chk("s9_sdout", t_sdout[9+LAT], din);
      chk("s9_col", t_sa[9+LAT], colx);
      chk("s9_dqm", t_dqm[9+LAT], dqx);
    end
    chk("s10_cmd", t_cmd[10+LAT], NOP);
    chk("s11_cmd", t_cmd[11+LAT], (en && due) ? PRE : NOP);
    chk("s12_cmd", t_cmd[12+LAT], (en && due) ? AREF : NOP);
    chk("s15_rdoe", t_rdoe[15+LAT], en && rd);

    if (wr && !data) ma[ch] = wreg(a, off, din);
    if (data) ma[ch] = (a + 24'd1) & MASK;
  endtask

  initial begin
    int cnt;
    logic found;
    for (int i = 0; i < 4; i++) ma[i] = '0;
    mref = 0;
    res = 1'b1; phi0 = 1'b0; init_done = 1'b1;
    ra = '0; ndevsel = 1'b1; nwe = 1'b1; rdin = '0; sdin = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd", cmd, NOP);
    chk("rst_rcke", rcke, 0);
    chk("rst_dqm", {dqmh, dqml}, 2'b11);
    chk("rst_sba", sba, 0);
    chk("rst_sa", sa, 0);
    chk("rst_rdout", rdout, 0);
    chk("rst_rdoe", rdoe, 0);
    chk("rst_sdout", sdout, 0);
    chk("rst_sdoe", sdoe, 0);
    @(negedge clk);
    res = 1'b0;
    @(posedge clk);
    #1;
    chk("rcke_up", rcke, 1);

    bus(4'h4, 1'b0, 1'b0, 8'hFF, 8'h00);
    bus(4'h5, 1'b0, 1'b0, 8'hFF, 8'h00);
    bus(4'h6, 1'b0, 1'b0, 8'h12, 8'h00);
    bus(4'h7, 1'b1, 1'b0, 8'h00, 8'h5A);
    bus(4'h6, 1'b1, 1'b0, 8'h00, 8'h00);
    bus(4'h5, 1'b1, 1'b0, 8'h00, 8'h00);
    bus(4'h4, 1'b1, 1'b0, 8'h00, 8'h00);

    bus(4'h0, 1'b0, 1'b0, 8'h80, 8'h00);
    bus(4'h0, 1'b0, 1'b0, 8'h05, 8'h00);
    bus(4'h0, 1'b1, 1'b0, 8'h00, 8'h00);
    bus(4'h1, 1'b1, 1'b0, 8'h00, 8'h00);
    bus(4'h0, 1'b0, 1'b0, 8'h85, 8'h00);
    bus(4'h0, 1'b1, 1'b0, 8'h00, 8'h00);
    bus(4'h1, 1'b1, 1'b0, 8'h00, 8'h00);

    bus(4'hA, 1'b0, 1'b0, 8'hFF, 8'h00);
    bus(4'h9, 1'b0, 1'b0, 8'hFF, 8'h00);
    bus(4'h8, 1'b0, 1'b0, 8'hFF, 8'h00);
    bus(4'hA, 1'b1, 1'b0, 8'h00, 8'h00);
    bus(4'hB, 1'b0, 1'b0, 8'h3C, 8'h00);
    bus(4'h8, 1'b1, 1'b0, 8'h00, 8'h00);
    bus(4'h9, 1'b1, 1'b0, 8'h00, 8'h00);
    bus(4'hA, 1'b1, 1'b0, 8'h00, 8'h00);

    bus(4'hF, 1'b1, 1'b0, 8'h00, 8'h11);
    bus(4'hC, 1'b0, 1'b0, 8'h55, 8'h00);
    bus(4'h7, 1'b1, 1'b1, 8'h00, 8'h22);

    repeat (64) begin
      bus(4'($urandom), 1'($urandom), $urandom_range(0, 7) == 0,
          8'($urandom), 8'($urandom));
    end

    init_done = 1'b0;
    repeat (10) begin
      bus({2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))},
          1'($urandom), 1'b0, 8'($urandom), 8'($urandom));
    end
    init_done = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int o = 0; o < 3; o++) begin
        bus({2'(c), 2'(o)}, 1'b1, 1'b0, 8'h00, 8'h00);
      end
    end

    cnt = 0;
    found = 1'b0;
    while (cnt < 1200 && !found) begin
      @(posedge clk);
      #1;
      cnt++;
      if (cmd == PRE) found = 1'b1;
    end
    chk("idle_pre_seen", found, 1);
    chk("idle_pre_late", cnt >= IDLE_REF, 1);
    chk("idle_pre_soon", cnt <= IDLE_REF + 30, 1);
    @(posedge clk);
    #1;
    chk("idle_aref", cmd, AREF);
    repeat (6) @(posedge clk);

    bus(4'h0, 1'b0, 1'b0, 8'h9A, 8'h00);
    @(negedge clk);
    ra = 4'h3; nwe = 1'b0; ndevsel = 1'b0; rdin = 8'h77; phi0 = 1'b1;
    for (int k = 1; k <= 9 + LAT; k++) begin
      @(posedge clk);
      #1;
      if (k == 8) phi0 = 1'b0;
    end
    chk("mid_wr_cmd", cmd, WRC);
    chk("mid_wr_sdoe", sdoe, 1);
    #5;
    res = 1'b1;
    #1;
    chk("mid_rst_cmd", cmd, NOP);
    chk("mid_rst_sdoe", sdoe, 0);
    chk("mid_rst_rcke", rcke, 0);
    for (int i = 0; i < 4; i++) ma[i] = '0;
    mref = 0;
    @(negedge clk);
    res = 1'b0;
    repeat (2) @(posedge clk);
    for (int o = 0; o < 3; o++) bus({2'd0, 2'(o)}, 1'b1, 1'b0, 8'h00, 8'h00);
    bus(4'h3, 1'b1, 1'b0, 8'h00, 8'h44);
    bus(4'h0, 1'b1, 1'b0, 8'h00, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
